// File: rtl/lcd_cmd_sequencer.sv
// HD44780 4-bit mode timing sequencer: power-up init, then byte writes as two
// E-strobed nibbles, with every delay counted in SYS_CLK cycles.
module lcd_cmd_sequencer #(
  parameter int P_PWRUP      = 1875000,
  parameter int P_INIT_WAIT  = 512500,
  parameter int P_INIT_SHORT = 12500,
  parameter int P_SETUP      = 10,
  parameter int P_EN_HIGH    = 60,
  parameter int P_NIB_GAP    = 125,
  parameter int P_CMD_WAIT   = 5000,
  parameter int P_CLR_WAIT   = 200000
) (
  input  logic       SYS_CLK,
  input  logic       SYS_RST_N,
  input  logic       CMD_VALID,
  input  logic       CMD_RS,
  input  logic [7:0] CMD_DATA,
  output logic       CMD_READY,
  output logic       INIT_DONE,
  output logic       LCD_RS,
  output logic       LCD_E,
  output logic [3:0] LCD_D,
  output logic [3:0] o_dbg_state
);

  // Handshake: a byte transfers on a rising edge where CMD_VALID and CMD_READY
  // are both high; CMD_RS/CMD_DATA are sampled on that edge only, and
  // CMD_VALID while CMD_READY is low is ignored (upstream keeps holding it).

  localparam int W_CNT = 21;

  // A state of P cycles loads P-1 and leaves when the counter reads zero.
  function automatic logic [W_CNT-1:0] cnt_load(input int p);
    return (p <= 1) ? '0 : W_CNT'(p - 1);
  endfunction

  localparam logic [W_CNT-1:0] L_PWRUP      = cnt_load(P_PWRUP);
  localparam logic [W_CNT-1:0] L_INIT_WAIT  = cnt_load(P_INIT_WAIT);
  localparam logic [W_CNT-1:0] L_INIT_SHORT = cnt_load(P_INIT_SHORT);
  localparam logic [W_CNT-1:0] L_SETUP      = cnt_load(P_SETUP);
  localparam logic [W_CNT-1:0] L_EN_HIGH    = cnt_load(P_EN_HIGH);
  localparam logic [W_CNT-1:0] L_NIB_GAP    = cnt_load(P_NIB_GAP);
  localparam logic [W_CNT-1:0] L_CMD_WAIT   = cnt_load(P_CMD_WAIT);
  localparam logic [W_CNT-1:0] L_CLR_WAIT   = cnt_load(P_CLR_WAIT);

  typedef enum logic [3:0] {
    S_PWRUP, S_INIT_NIB, S_IDLE, S_SETUP_HI, S_EN_HI_HI,
    S_GAP, S_SETUP_LO, S_EN_HI_LO, S_WAIT
  } state_t;

  function automatic logic [7:0] init_byte(input logic [2:0] step);
    logic [7:0] b;
    case (step)
      3'd4:    b = 8'h28;
      3'd5:    b = 8'h0C;
      3'd6:    b = 8'h01;
      3'd7:    b = 8'h06;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t           r_state, w_state;
  logic [W_CNT-1:0] r_cnt, w_cnt, w_wait_ld;
  logic [2:0]       r_step, w_step;
  logic             r_rs, w_rs;
  logic [7:0]       r_data, w_data;
  logic             r_done, w_done;
  logic             r_ready, w_ready;
  logic             r_lcd_rs, w_lcd_rs;
  logic             r_lcd_e, w_lcd_e;
  logic [3:0]       r_lcd_d, w_lcd_d;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);

  // Steps 0..3 are nibble-only init writes with their own fixed waits.
  always_comb begin
    w_wait_ld = L_CMD_WAIT;
    if (!r_done && (r_step < 3'd4)) begin
      case (r_step)
        3'd0:    w_wait_ld = L_INIT_WAIT;
        3'd1:    w_wait_ld = L_INIT_SHORT;
        default: w_wait_ld = L_CMD_WAIT;
      endcase
    end else if (!r_rs && ((r_data == 8'h01) || (r_data == 8'h02))) begin
      w_wait_ld = L_CLR_WAIT;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = w_zero ? '0 : r_cnt - W_CNT'(1);
    w_step   = r_step;
    w_rs     = r_rs;
    w_data   = r_data;
    w_done   = r_done;
    w_lcd_rs = r_lcd_rs;
    w_lcd_e  = r_lcd_e;
    w_lcd_d  = r_lcd_d;
    case (r_state)
      S_PWRUP: if (w_zero) begin
        w_state  = S_INIT_NIB;
        w_cnt    = L_SETUP;
        w_rs     = 1'b0;
        w_data   = 8'h30;
        w_lcd_rs = 1'b0;
        w_lcd_d  = 4'h3;
      end
      S_INIT_NIB: if (w_zero) begin
        w_state = S_EN_HI_LO;
        w_cnt   = L_EN_HIGH;
        w_lcd_e = 1'b1;
      end
      S_IDLE: if (CMD_VALID && r_ready) begin
        w_state  = S_SETUP_HI;
        w_cnt    = L_SETUP;
        w_rs     = CMD_RS;
        w_data   = CMD_DATA;
        w_lcd_rs = CMD_RS;
        w_lcd_d  = CMD_DATA[7:4];
      end
      S_SETUP_HI: if (w_zero) begin
        w_state = S_EN_HI_HI;
        w_cnt   = L_EN_HIGH;
        w_lcd_e = 1'b1;
      end
      S_EN_HI_HI: if (w_zero) begin
        w_state = S_GAP;
        w_cnt   = L_NIB_GAP;
        w_lcd_e = 1'b0;
      end
      S_GAP: if (w_zero) begin
        w_state = S_SETUP_LO;
        w_cnt   = L_SETUP;
        w_lcd_d = r_data[3:0];
      end
      S_SETUP_LO: if (w_zero) begin
        w_state = S_EN_HI_LO;
        w_cnt   = L_EN_HIGH;
        w_lcd_e = 1'b1;
      end
      S_EN_HI_LO: if (w_zero) begin
        w_state = S_WAIT;
        w_cnt   = w_wait_ld;
        w_lcd_e = 1'b0;
      end
      S_WAIT: if (w_zero) begin
        if (r_done) begin
          w_state = S_IDLE;
        end else if (r_step == 3'd7) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
        end else begin
          // Advance the init list; RS/D change only here, with E already low.
          w_step   = r_step + 3'd1;
          w_cnt    = L_SETUP;
          w_rs     = 1'b0;
          w_lcd_rs = 1'b0;
          if (w_step < 3'd4) begin
            w_state = S_INIT_NIB;
            w_data  = {((w_step == 3'd3) ? 4'h2 : 4'h3), 4'h0};
          end else begin
            w_state = S_SETUP_HI;
            w_data  = init_byte(w_step);
          end
          w_lcd_d = w_data[7:4];
        end
      end
      default: w_state = S_PWRUP;
    endcase
    w_ready = (w_state == S_IDLE) && w_done;
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_state  <= S_PWRUP;
      r_cnt    <= L_PWRUP;
      r_step   <= 3'd0;
      r_rs     <= 1'b0;
      r_data   <= 8'h00;
      r_done   <= 1'b0;
      r_ready  <= 1'b0;
      r_lcd_rs <= 1'b0;
      r_lcd_e  <= 1'b0;
      r_lcd_d  <= 4'h0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_step   <= w_step;
      r_rs     <= w_rs;
      r_data   <= w_data;
      r_done   <= w_done;
      r_ready  <= w_ready;
      r_lcd_rs <= w_lcd_rs;
      r_lcd_e  <= w_lcd_e;
      r_lcd_d  <= w_lcd_d;
    end
  end

  assign CMD_READY   = r_ready;
  assign INIT_DONE   = r_done;
  assign LCD_RS      = r_lcd_rs;
  assign LCD_E       = r_lcd_e;
  assign LCD_D       = r_lcd_d;
  assign o_dbg_state = r_state;

endmodule
